// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and constants for the RV32I multi-cycle control path
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IMEM_TO = 2'b10;
    localparam logic [1:0] ERR_DMEM_TO = 2'b11;

endpackage

// File: rtl/req_timeout.sv
// rtl/req_timeout.sv - saturating wait counter shared by the fetch and data request phases
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clear       restart the count (asserted on entry to a request state)
//   active      a request is outstanding this cycle
//   ack         the outstanding request completes this cycle
//   expired     this is the MEM_TIMEOUT-th consecutive cycle without ack
module req_timeout #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired
);

    // count holds the number of earlier ack-less cycles, so the current
    // cycle is the last allowed one once count reaches MEM_TIMEOUT-1.
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (active && !ack && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // An ack in the limit cycle wins over expiry.
    assign expired = active && !ack && (count >= LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for RV32I
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   opcode                  IR[6:0], sampled in DECODE
//   alu_zero                ALU zero flag, selects branch target in EXEC
//   imem_req / imem_ack     instruction fetch handshake
//   dmem_req / dmem_we      data access request and direction (1 = store)
//   dmem_ack                data access complete
//   ir_write, pc_write      IR and PC load enables
//   pc_src                  0 = PC+4, 1 = branch target
//   alu_src, alu_op         ALU operand and operation selects
//   reg_write, mem_to_reg   register file write enable and writeback source
//   retire, instret         retire pulse and retired-instruction count
//   halted, err_code        trap indication and cause
module multicycle_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        alu_zero,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  err_code
);

    state_e     state, state_n;
    class_e     cls, cls_n;
    logic [1:0] err_q, err_n;

    logic to_clear, to_active, to_ack, to_expired;

    // FETCH and MEM never overlap, so one counter serves both.
    assign to_active = (state == ST_FETCH) || (state == ST_MEM);
    assign to_ack    = (state == ST_FETCH) ? imem_ack : dmem_ack;
    assign to_clear  = (state_n != state) &&
                       ((state_n == ST_FETCH) || (state_n == ST_MEM));

    req_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_req_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (to_clear),
        .active  (to_active),
        .ack     (to_ack),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            cls     <= CLS_R;
            err_q   <= ERR_NONE;
            instret <= '0;
        end else begin
            state <= state_n;
            cls   <= cls_n;
            err_q <= err_n;
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        cls_n      = cls;
        err_n      = err_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_OP_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    state_n  = ST_DECODE;
                end else if (to_expired) begin
                    state_n = ST_TRAP;
                    err_n   = ERR_IMEM_TO;
                end
            end
            ST_DECODE: begin
                state_n = ST_EXEC;
                case (opcode)
                    OP_R:      cls_n = CLS_R;
                    OP_LOAD:   cls_n = CLS_LOAD;
                    OP_STORE:  cls_n = CLS_STORE;
                    OP_BRANCH: cls_n = CLS_BRANCH;
                    default: begin
                        state_n = ST_TRAP;
                        err_n   = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R: begin
                        alu_op  = ALU_OP_FUNCT;
                        state_n = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src = 1'b1;
                        state_n = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        // Branch resolves here; pc_src follows the live zero flag.
                        alu_op   = ALU_OP_SUB;
                        pc_write = 1'b1;
                        pc_src   = alu_zero;
                        retire   = 1'b1;
                        state_n  = ST_FETCH;
                    end
                    default: state_n = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CLS_STORE);
                alu_src  = 1'b1;
                if (dmem_ack) begin
                    if (cls == CLS_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_n  = ST_FETCH;
                    end else begin
                        state_n = ST_WB;
                    end
                end else if (to_expired) begin
                    state_n = ST_TRAP;
                    err_n   = ERR_DMEM_TO;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == CLS_LOAD);
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_n    = ST_FETCH;
            end
            ST_TRAP: begin
                halted = 1'b1;
            end
            default: state_n = ST_FETCH;
        endcase
    end

    assign err_code = err_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, memory access and writeback over several clock cycles. It does this for R-type, load, store and branch instructions.
- Drives the datapath enables, the ALU source and ALU operation selects, and the memory request handshakes.
- Counts retired instructions and halts into a trap state on an illegal opcode or a memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: number of consecutive request cycles without an ack before the block traps. Legal range is 1 to 255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-low.
- opcode  in  7  instruction[6:0], read from the IR output. It is sampled in DECODE.
- alu_zero  in  1  ALU zero flag. It is used only in EXEC for branches.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; the IR data is valid in this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 means store, 0 means load. Valid only while dmem_req is high.
- dmem_ack  in  1  data access complete.
- ir_write  out  1  load the IR.
- pc_write  out  1  update the PC.
- pc_src  out  1  0 selects PC+4, 1 selects the branch target.
- alu_src  out  1  0 selects rs2, 1 selects the immediate.
- alu_op  out  2  ALU operation class.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 1 selects memory data, 0 selects the ALU result.
- retire  out  1  one-cycle pulse per retired instruction.
- instret  out  32  retired-instruction count. Wraps from 0xFFFFFFFF to 0.
- halted  out  1  high while in TRAP.
- err_code  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Outputs depend on the state and the latched instruction class. The exception is pc_src in EXEC for branches, which equals alu_zero (Mealy).
- Any output not listed for a state is 0.

State behaviour:
- FETCH: imem_req=1.
  - On imem_ack: ir_write=1, go to DECODE.
- DECODE: latch the class from opcode.
  - 0110011 is R; 0000011 is LOAD; 0100011 is STORE; 1100011 is BRANCH.
  - Any other opcode: go to TRAP with err_code=01.
  - Otherwise go to EXEC.
- EXEC:
  - R: alu_src=0, alu_op=10, go to WB.
  - LOAD or STORE: alu_src=1, alu_op=00, go to MEM.
  - BRANCH: alu_src=0, alu_op=01, pc_write=1, pc_src=alu_zero, retire=1, go to FETCH.
- MEM: dmem_req=1, dmem_we=(class==STORE), alu_src=1, alu_op=00.
  - On dmem_ack with STORE: pc_write=1, pc_src=0, retire=1, go to FETCH.
  - On dmem_ack with LOAD: go to WB.
- WB: reg_write=1, mem_to_reg=(class==LOAD), pc_write=1, pc_src=0, retire=1, go to FETCH.
- TRAP: halted=1 and err_code is held. The block stays in TRAP until reset.

Handshake rules:
- A request is held high until its ack is sampled.
- An ack arriving while its request is low is ignored.
- dmem_we is stable for the whole request.

Timeout:
- The counter clears when the block enters FETCH or MEM.
- It increments in each FETCH or MEM cycle that has no ack.
- When MEM_TIMEOUT consecutive cycles pass without an ack, the block enters TRAP on the next edge with err_code=10 (imem) or 11 (dmem).
- If the ack arrives in the same cycle the limit is reached, the ack wins and the block does not trap.

instret increments on every retire pulse.

## Timing
Reset:
- rst_n low at a rising edge forces the state to FETCH. It also sets instret=0, err_code=00, halted=0, and clears the timeout counter and class register.
- This applies from any state, including mid-handshake. Any outstanding request is abandoned: dmem_req drops on the next edge.
- In the first cycle after reset: imem_req=1 and every other output is 0.

Latency from FETCH entry to retire, with zero-wait acks (ack in the first request cycle):
- BRANCH: 3 cycles.
- R: 4 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.
- Each wait cycle adds one cycle.

Retire and writeback timing:
- retire and pc_write occur in the same cycle, and there is exactly one per instruction.
- reg_write is never high outside WB.

## Structure
- rv_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_R, OP_LOAD, OP_STORE, OP_BRANCH);
  - the class enum;
  - ALU_OP_ADD=00, ALU_OP_SUB=01, ALU_OP_FUNCT=10;
  - err_code constants.
- Sub-module req_timeout: a saturating wait counter with inputs clear, active, ack and the MEM_TIMEOUT parameter, and output expired. It is instantiated once and shared by FETCH and MEM, since those states are mutually exclusive.

## Test plan
- Reset, then R-type (0110011) with imem_ack in the first cycle:
  - ir_write pulses in cycle 1.
  - reg_write=1, mem_to_reg=0 and retire in cycle 4.
  - instret=1.
- LOAD with dmem_ack delayed 3 cycles:
  - dmem_req=1 and dmem_we=0 for 4 cycles.
  - WB has mem_to_reg=1.
  - retire arrives 8 cycles after FETCH entry.
- STORE then BRANCH:
  - STORE: dmem_we=1 and retire without reg_write.
  - BRANCH with alu_zero=1: pc_src=1 and retire in cycle 3.
  - BRANCH with alu_zero=0: pc_src=0.
- Opcode 0010011:
  - TRAP with err_code=01 and halted=1.
  - No further requests for 20 cycles.
  - rst_n low for one edge returns the block to FETCH with err_code=00.
- MEM_TIMEOUT=15 with imem_ack never asserted:
  - TRAP with err_code=10 after 15 request cycles.
  - Repeat with the ack in the 15th cycle: the block goes to DECODE with no trap.
- Reset asserted mid-MEM while dmem_req=1:
  - dmem_req=0 and the state is FETCH on the next edge.
  - instret=0.
  - A late dmem_ack is ignored.
